// File: rtl/breath_pkg.sv
// Shared types and constants for the running-breath LED sequencer.
package breath_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam logic LED_ON  = 1'b0;
  localparam logic LED_OFF = 1'b1;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned bits_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/breath_timebase.sv
// Free-running us tick and PWM frame position counters with synchronous clear.
module breath_timebase
  import breath_pkg::*;
#(
  parameter int unsigned CLK_PER_US = 50,
  parameter int unsigned STEPS      = 1000
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       clr,
  output logic                       tick,
  output logic [bits_for(STEPS)-1:0] pos,
  output logic                       frame_end
);

  localparam int unsigned CW = bits_for(CLK_PER_US);
  localparam int unsigned PW = bits_for(STEPS);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLK_PER_US - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(STEPS - 1);

  logic [CW-1:0] clk_cnt;

  assign tick      = (clk_cnt == CLK_LAST);
  assign frame_end = tick && (pos == POS_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clk_cnt <= '0;
      pos     <= '0;
    end else if (clr) begin
      clk_cnt <= '0;
      pos     <= '0;
    end else if (tick) begin
      clk_cnt <= '0;
      pos     <= (pos == POS_LAST) ? '0 : pos + PW'(1);
    end else begin
      clk_cnt <= clk_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/breath_seq_ctrl.sv
// Schedules one shared PWM breath engine across LED_NUM LEDs, one LED at a time,
// with a dark gap between LEDs.
module breath_seq_ctrl
  import breath_pkg::*;
#(
  parameter int unsigned CLK_PER_US = 50,
  parameter int unsigned STEPS      = 1000,
  parameter int unsigned LED_NUM    = 4,
  parameter int unsigned GAP_FRAMES = 200
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       en,
  input  logic                       dir,
  output logic [LED_NUM-1:0]         led_out,
  output logic                       busy,
  output logic [$clog2(LED_NUM)-1:0] cur_led
);

  localparam int unsigned DW = bits_for(STEPS);
  localparam int unsigned GW = bits_for(GAP_FRAMES);
  localparam int unsigned LW = $clog2(LED_NUM);

  localparam logic [DW-1:0] DUTY_MAX  = DW'(STEPS - 1);
  localparam logic [DW-1:0] DUTY_TURN = DW'(STEPS - 2);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_FRAMES - 1);
  localparam logic [LW-1:0] LED_LAST  = LW'(LED_NUM - 1);

  state_e              state_q;
  state_e              state_nxt;
  logic [DW-1:0]       duty_q;
  logic [DW-1:0]       duty_nxt;
  logic [GW-1:0]       gap_q;
  logic [GW-1:0]       gap_nxt;
  logic [LW-1:0]       cur_led_nxt;
  logic [LED_NUM-1:0]  led_nxt;
  logic                busy_nxt;

  logic                tb_clr;
  logic                tick_unused;
  logic [DW-1:0]       pos;
  logic                frame_end;
  logic                gap_end;
  logic                pwm_on;

  // Timebase only runs while a breath or gap is in progress.
  assign tb_clr  = (state_q == IDLE);
  assign gap_end = frame_end && (gap_q == GAP_LAST);
  assign pwm_on  = (pos < duty_q);

  breath_timebase #(
    .CLK_PER_US (CLK_PER_US),
    .STEPS      (STEPS)
  ) u_timebase (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (tb_clr),
    .tick      (tick_unused),
    .pos       (pos),
    .frame_end (frame_end)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (en) state_nxt = RISE;
      RISE:    if (frame_end && (duty_q == DUTY_MAX)) state_nxt = FALL;
      FALL:    if (frame_end && (duty_q == '0)) state_nxt = GAP;
      GAP:     if (gap_end) state_nxt = en ? RISE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    duty_nxt    = duty_q;
    gap_nxt     = gap_q;
    cur_led_nxt = cur_led;
    led_nxt     = {LED_NUM{LED_OFF}};
    busy_nxt    = (state_nxt != IDLE);

    case (state_q)
      IDLE: begin
        duty_nxt = '0;
        gap_nxt  = '0;
      end
      RISE: begin
        if (frame_end) duty_nxt = (duty_q == DUTY_MAX) ? DUTY_TURN : duty_q + DW'(1);
      end
      FALL: begin
        if (frame_end) begin
          if (duty_q == '0) gap_nxt = '0;
          else              duty_nxt = duty_q - DW'(1);
        end
      end
      GAP: begin
        if (gap_end) begin
          gap_nxt  = '0;
          duty_nxt = '0;
          if (dir) cur_led_nxt = (cur_led == '0) ? LED_LAST : cur_led - LW'(1);
          else     cur_led_nxt = (cur_led == LED_LAST) ? '0 : cur_led + LW'(1);
        end else if (frame_end) begin
          gap_nxt = gap_q + GW'(1);
        end
      end
      default: ;
    endcase

    // Only the LED owning the engine is driven, and only while breathing.
    if ((state_q == RISE) || (state_q == FALL)) begin
      for (int unsigned i = 0; i < LED_NUM; i++) begin
        if ((LW'(i) == cur_led) && pwm_on) led_nxt[i] = LED_ON;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      duty_q  <= '0;
      gap_q   <= '0;
      cur_led <= '0;
      led_out <= {LED_NUM{LED_OFF}};
      busy    <= 1'b0;
    end else begin
      duty_q  <= duty_nxt;
      gap_q   <= gap_nxt;
      cur_led <= cur_led_nxt;
      led_out <= led_nxt;
      busy    <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_breath_seq_ctrl.sv
// Scoreboard bench for breath_seq_ctrl using a cycle-offset model of the breath period.
module tb_breath_seq_ctrl;

  localparam int CLK_PER_US = 2;
  localparam int STEPS      = 4;
  localparam int LED_NUM    = 4;
  localparam int GAP_FRAMES = 2;
  localparam int FRAME      = CLK_PER_US * STEPS;
  localparam int BREATH_FR  = 2 * STEPS - 1;
  localparam int PERIOD     = (BREATH_FR + GAP_FRAMES) * FRAME;

  typedef struct packed {
    logic [LED_NUM-1:0] led;
    logic               busy;
    logic [1:0]         cur;
  } exp_t;

  logic               sys_clk;
  logic               sys_rst_n;
  logic               en;
  logic               dir;
  logic [LED_NUM-1:0] led_out;
  logic               busy;
  logic [1:0]         cur_led;

  exp_t sb_q[$];
  int   n_vec;
  int   n_err;

  int   m_active;
  int   m_k;
  int   m_cur;

  breath_seq_ctrl #(
    .CLK_PER_US (CLK_PER_US),
    .STEPS      (STEPS),
    .LED_NUM    (LED_NUM),
    .GAP_FRAMES (GAP_FRAMES)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (en),
    .dir       (dir),
    .led_out   (led_out),
    .busy      (busy),
    .cur_led   (cur_led)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  // Expected outputs after this edge; LED compare uses the pre-edge offset (1-clk latency).
  task automatic model_step();
    exp_t e;
    int   f;
    int   p;
    int   d;
    e.led = '1;
    if (!sys_rst_n) begin
      m_active = 0;
      m_k      = 0;
      m_cur    = 0;
      e.busy   = 1'b0;
      e.cur    = 2'd0;
    end else begin
      if (m_active != 0) begin
        f = m_k / FRAME;
        p = (m_k % FRAME) / CLK_PER_US;
        d = (f < STEPS) ? f : (2 * STEPS - 2 - f);
        if ((f < BREATH_FR) && (p < d)) e.led[m_cur] = 1'b0;
      end
      if (m_active == 0) begin
        if (en) begin
          m_active = 1;
          m_k      = 0;
        end
      end else if (m_k == PERIOD - 1) begin
        m_cur    = dir ? (m_cur + LED_NUM - 1) % LED_NUM : (m_cur + 1) % LED_NUM;
        m_k      = 0;
        m_active = en ? 1 : 0;
      end else begin
        m_k++;
      end
      e.busy = (m_active != 0);
      e.cur  = 2'(m_cur);
    end
    sb_q.push_back(e);
  endtask

  initial begin
    m_active = 0;
    m_k      = 0;
    m_cur    = 0;
    forever begin
      @(posedge sys_clk);
      model_step();
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (sb_q.size() == 0) begin
        check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check_val("led_out", 32'(led_out), 32'(e.led));
        check_val("busy",    32'(busy),    32'(e.busy));
        check_val("cur_led", 32'(cur_led), 32'(e.cur));
      end
    end
  end

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    en        = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    sys_rst_n = 1'b0;
    en        = 1'b0;
    dir       = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Idle with en low
    repeat (100) @(negedge sys_clk);
    check_val("idle_led",  32'(led_out), 32'hF);
    check_val("idle_busy", 32'(busy),    32'd0);
    check_val("idle_cur",  32'(cur_led), 32'd0);

    // Increment order with wrap
    en = 1'b1;
    repeat (300) @(negedge sys_clk);
    en = 1'b0;
    repeat (2 * PERIOD) @(negedge sys_clk);
    check_val("run_stop_busy", 32'(busy), 32'd0);

    // Graceful stop: en dropped during LED0 rise
    do_reset();
    dir = 1'b0;
    en  = 1'b1;
    repeat (10) @(negedge sys_clk);
    en = 1'b0;
    repeat (100) @(negedge sys_clk);
    check_val("stop_cur",  32'(cur_led), 32'd1);
    check_val("stop_busy", 32'(busy),    32'd0);
    check_val("stop_led",  32'(led_out), 32'hF);

    // Decrement order
    do_reset();
    dir = 1'b1;
    en  = 1'b1;
    repeat (300) @(negedge sys_clk);
    en = 1'b0;
    repeat (2 * PERIOD) @(negedge sys_clk);
    dir = 1'b0;

    // Async reset during the fall phase
    do_reset();
    en = 1'b1;
    repeat (40) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check_val("arst_led",  32'(led_out), 32'hF);
    check_val("arst_busy", 32'(busy),    32'd0);
    check_val("arst_cur",  32'(cur_led), 32'd0);
    en = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);
    check_val("post_rst_busy", 32'(busy), 32'd0);
    en = 1'b1;
    repeat (30) @(negedge sys_clk);
    en = 1'b0;
    repeat (PERIOD + 10) @(negedge sys_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
